// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, round-constant table and size helpers.
//   state_t      : key-expander FSM states
//   rcon()       : round constant lookup, index 0..9 (0 beyond the table)
//   nk_of/nr_of/nw_of : key words, rounds and schedule words for a key length
package aes_pkg;
    typedef enum logic [1:0] {IDLE, EXPAND, FIN} state_t;
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction
    function automatic int nr_of(input int key_bits);
        return nk_of(key_bits) + 6;
    endfunction
    function automatic int nw_of(input int key_bits);
        return 4 * (nr_of(key_bits) + 1);
    endfunction
    function automatic logic [7:0] rcon(input logic [3:0] i);
        return (i < 4'd10) ? RCON[i] : 8'h00;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: AES byte S-box, forward or inverse, built from GF(2^8) inversion plus affine map.
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   din  : input byte
//   dout : substituted byte
module aes_sbox (
    input  logic       inv,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction
    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = mul(s, s);
            r = mul(r, s);
        end
        return r;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction
    function automatic logic [7:0] aff(input logic [7:0] b);
        return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    endfunction
    function automatic logic [7:0] iaff(input logic [7:0] b);
        return rl(b, 1) ^ rl(b, 3) ^ rl(b, 6) ^ 8'h05;
    endfunction
    assign dout = inv ? ginv(iaff(din)) : aff(ginv(din));
endmodule

// File: rtl/aes_sub_word.sv
// aes_sub_word: 32-bit SubWord, four forward S-boxes applied bytewise.
//   din  : input word
//   dout : substituted word
module aes_sub_word (
    input  logic [31:0] din,
    output logic [31:0] dout
);
    for (genvar j = 0; j < 4; j++) begin : g_sb
        aes_sbox u_sb (.inv(1'b0), .din(din[8*j +: 8]), .dout(dout[8*j +: 8]));
    end
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule, one word per clock, round-key store.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse to latch key and expand (ignored while busy)
//   key       : cipher key, word 0 in the MSBs
//   busy/done : expansion in progress / one-cycle completion pulse
//   rk_idx    : round index to read; rk_out/rk_valid follow one clock later
//   rk_rev    : only with AES_KEYEXP_DEC_ORDER_EN, reads round NR-rk_idx
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                done,
`ifdef AES_KEYEXP_DEC_ORDER_EN
    input  logic                rk_rev,
`endif
    input  logic [3:0]          rk_idx,
    output logic [127:0]        rk_out,
    output logic                rk_valid
);
    localparam int NK = nk_of(KEY_BITS);
    localparam int NR = nr_of(KEY_BITS);
    localparam int NW = nw_of(KEY_BITS);
    localparam logic [5:0] NK_W = 6'(NK);
    localparam logic [5:0] LAST = 6'(NW - 1);
    localparam logic [3:0] NR_W = 4'(NR);
    localparam logic [2:0] K_LAST = 3'(NK - 1);
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end
    state_t      state, state_n;
    logic [5:0]  wr_cnt;
    logic [2:0]  k_pos;
    logic [3:0]  rc_idx;
    logic [31:0] w [NW];
    logic [31:0] prev, sub_in, sub_out, temp, new_w;
    logic [3:0]  eff;
    logic        rd_ok, load;
    assign busy   = state == EXPAND;
    assign done   = state == FIN;
    assign load   = start && state != EXPAND;
    assign prev   = w[wr_cnt - 6'd1];
    // one shared SubWord: rotated input on word boundaries, plain input for the 256-bit mid-key step
    assign sub_in = (k_pos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    aes_sub_word u_sub (.din(sub_in), .dout(sub_out));
    always_comb begin
        temp    = (k_pos == 3'd0) ? sub_out ^ {rcon(rc_idx), 24'h0}
                : (NK == 8 && k_pos == 3'd4) ? sub_out : prev;
        new_w   = w[wr_cnt - NK_W] ^ temp;
        state_n = load ? EXPAND : (state == EXPAND) ? ((wr_cnt == LAST) ? FIN : EXPAND) : IDLE;
`ifdef AES_KEYEXP_DEC_ORDER_EN
        eff     = rk_rev ? NR_W - rk_idx : rk_idx;
`else
        eff     = rk_idx;
`endif
        // a round is readable once its last word lies below the write pointer
        rd_ok   = (eff <= NR_W) && ({eff, 2'b11} < wr_cnt);
    end
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < NK; j++) w[6'(j)] <= key[KEY_BITS-1-32*j -: 32];
        end else if (busy) begin
            w[wr_cnt] <= new_w;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_cnt   <= '0;
            k_pos    <= '0;
            rc_idx   <= '0;
            rk_valid <= 1'b0;
            rk_out   <= '0;
        end else begin
            state    <= state_n;
            rk_valid <= rd_ok;
            rk_out   <= rd_ok ? {w[{eff, 2'b00}], w[{eff, 2'b01}], w[{eff, 2'b10}], w[{eff, 2'b11}]} : '0;
            if (load) begin
                wr_cnt <= NK_W;
                k_pos  <= '0;
                rc_idx <= '0;
            end else if (busy) begin
                wr_cnt <= wr_cnt + 6'd1;
                k_pos  <= (k_pos == K_LAST) ? 3'd0 : k_pos + 3'd1;
                if (k_pos == 3'd0) rc_idx <= rc_idx + 4'd1;
            end
        end
    end
endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
Iterative AES key-schedule engine, parametrised for AES-128/192/256 via KEY_BITS.
- Loads a cipher key on a start pulse and generates one 32-bit schedule word per clock.
- Stores all 4*(Nr+1) words in an internal round-key store, which the round datapath reads by round index.
- Replaces the combinational single-round key step, so the cipher core no longer has to chain ten combinational round-key blocks.

Parameters:
KEY_BITS, 128, cipher key length; legal values 128, 192, 256 only (any other value is an elaboration error).
NK, KEY_BITS/32, derived localparam: key words (4/6/8).
NR, NK+6, derived localparam: number of rounds (10/12/14).
NW, 4*(NR+1), derived localparam: total schedule words (44/52/60).

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, latch key and begin expansion; ignored while busy=1
key  in  KEY_BITS  cipher key, word 0 = key[KEY_BITS-1 -: 32]; sampled only in the start cycle
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when the last word (NW-1) is written
rk_idx  in  4  round index to read, 0..NR
rk_out  out  128  round key for rk_idx = words 4*rk_idx..4*rk_idx+3, first word in MSBs
rk_valid  out  1  rk_out holds a fully generated round key

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, rk_valid=0, rk_out=0, state=IDLE, word counter wr_cnt=0.
- Store contents are don't-care after reset.
- States: IDLE -> EXPAND -> FIN -> IDLE.
- IDLE:
  - On start, write key words into w[0..NK-1], set wr_cnt=NK, and go to EXPAND.
  - busy rises in the cycle after start.
- EXPAND: each cycle computes w[i] for i=wr_cnt, then increments wr_cnt.
  - temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon[i/NK-1], 24'h0}.
  - Else if NK == 8 and i mod NK == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - RotWord is a left byte rotate.
  - rcon sequence is 01,02,04,08,10,20,40,80,1b,36, indexed from 0.
- Transition EXPAND -> FIN in the cycle w[NW-1] is written.
- EXPAND cycle counts from start to done: 40 (128), 46 (192), 52 (256). done asserts in the FIN cycle.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start in the FIN cycle is accepted.
- Read port:
  - One-cycle registered latency: rk_out and rk_valid update on the clock after rk_idx is presented.
  - rk_valid=1 iff rk_idx <= NR and words 4*rk_idx+3 < wr_cnt (or the store is complete).
  - Rounds already generated are therefore readable during expansion.
  - rk_idx > NR gives rk_valid=0 and rk_out=0.
- Restart: start while busy=1 is ignored. A new start in IDLE invalidates all rounds >= NK/4 until they are regenerated; rk_valid reflects this from the next cycle.
- Reset mid-expansion: abort immediately; store contents become invalid (rk_valid=0) until the next complete or partial expansion.
- rst has priority over start.

Optional Feature:
Macro AES_KEYEXP_DEC_ORDER_EN adds input port rk_rev (1 bit).
- rk_rev=1: the read index is mapped to NR-rk_idx, so decryption can walk rk_idx 0..NR upward.
- rk_rev=0: identical to the macro-undefined behaviour.
- The rk_valid range check uses the mapped index.
- Without the macro, the port does not exist and the read is always forward order.

Decomposition:
- Package aes_pkg:
  - RCON table (10 x 8-bit) as a constant function/array.
  - Localparam helpers NK/NR/NW derivation.
  - State enum {IDLE, EXPAND, FIN}.
- Sub-module aes_sub_word: 32-bit SubWord built from four forward S-box instances of the existing byte S-box (inverse select tied to 0).
- Instantiated once and shared by the RotWord and 256-bit mid-key paths via a mux in front.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done after 40 EXPAND cycles. Round1 = a0fafe1788542cb123a339392a6c7605; round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 cycles. Round12 = e98ba06f448c773c8ecc720401002202.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 cycles. Round14 = fe4890d1e6188d0b046df344706c631e; exercises the i mod 8 == 4 SubWord path.
- Read during expansion (128): poll rk_idx=2 every cycle from start -> rk_valid rises only once w[11] is written; rk_idx=11 -> rk_valid=0, rk_out=0.
- Second start pulse while busy -> ignored, done count stays 1. Assert rst at EXPAND cycle 20 -> busy=0 and rk_valid=0 next cycle; a fresh start then completes normally.
- With AES_KEYEXP_DEC_ORDER_EN and rk_rev=1, rk_idx=0 (128) -> rk_out = d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx=10 -> original key.
